// File: rtl/sc_mux81_scan_sampler.sv
// Scan sampler: steps an 8:1 mux select through all channels, waits a settle
// time per channel, samples the mux output and publishes a packed frame word.
module sc_mux81_scan_sampler #(
  parameter int SCAN_SELECTWIDTH = 4,
  parameter int SCAN_DIVWIDTH    = 8,
  parameter int SCAN_NUMCH       = 8
) (
  input  logic                        SC_SCAN_CLOCK_50,
  input  logic                        SC_SCAN_RESET_InLow,
  input  logic                        SC_SCAN_start_In,
  input  logic [SCAN_DIVWIDTH-1:0]    SC_SCAN_divider_InBUS,
  input  logic                        SC_SCAN_muxZ_In,
  output logic [SCAN_SELECTWIDTH-1:0] SC_SCAN_select_OutBUS,
  output logic [SCAN_NUMCH-1:0]       SC_SCAN_word_OutBUS,
  output logic                        SC_SCAN_busy_Out,
  output logic                        SC_SCAN_done_Out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [SCAN_SELECTWIDTH-1:0] LAST_CH =
    SCAN_SELECTWIDTH'(SCAN_NUMCH - 1);

  state_t                      state_q, state_d;
  logic [SCAN_SELECTWIDTH-1:0] ch_q, ch_d;
  logic [SCAN_DIVWIDTH-1:0]    cnt_q, cnt_d;
  logic [SCAN_DIVWIDTH-1:0]    dlat_q, dlat_d;
  logic [SCAN_NUMCH-1:0]       shadow_q, shadow_d;
  logic [SCAN_NUMCH-1:0]       word_q, word_d;
  logic [SCAN_SELECTWIDTH-1:0] sel_q, sel_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  always_ff @(posedge SC_SCAN_CLOCK_50 or negedge SC_SCAN_RESET_InLow) begin
    if (!SC_SCAN_RESET_InLow) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      dlat_q   <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      dlat_q   <= dlat_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    dlat_d   = dlat_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (SC_SCAN_start_In) begin
          dlat_d  = SC_SCAN_divider_InBUS;
          cnt_d   = SC_SCAN_divider_InBUS;
          ch_d    = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SAMPLE: begin
        for (int i = 0; i < SCAN_NUMCH; i++) begin
          if (ch_q == SCAN_SELECTWIDTH'(i)) shadow_d[i] = SC_SCAN_muxZ_In;
        end
        // publish together with the last sample so done lands on DONE
        if (ch_q == LAST_CH) begin
          word_d  = shadow_d;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          cnt_d   = dlat_q;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        ch_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    sel_d  = (state_d == S_IDLE) ? '0 : ch_d;
    busy_d = (state_d != S_IDLE);
  end

  assign SC_SCAN_select_OutBUS = sel_q;
  assign SC_SCAN_word_OutBUS   = word_q;
  assign SC_SCAN_busy_Out      = busy_q;
  assign SC_SCAN_done_Out      = done_q;

endmodule

// File: tb/tb_sc_mux81_scan_sampler.sv
// Directed bench for sc_mux81_scan_sampler with a behavioural 8:1 mux
// closing the loop from select back to muxZ.
module tb_sc_mux81_scan_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] div;
  logic [7:0] mux_data;
  logic       z;
  logic [3:0] sel;
  logic [7:0] word;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign z = mux_data[sel[2:0]];

  sc_mux81_scan_sampler dut (
    .SC_SCAN_CLOCK_50     (clk),
    .SC_SCAN_RESET_InLow  (rst_n),
    .SC_SCAN_start_In     (start),
    .SC_SCAN_divider_InBUS(div),
    .SC_SCAN_muxZ_In      (z),
    .SC_SCAN_select_OutBUS(sel),
    .SC_SCAN_word_OutBUS  (word),
    .SC_SCAN_busy_Out     (busy),
    .SC_SCAN_done_Out     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [7:0] exp_w,
                           input bit perturb, input string tag);
    int n;
    int done_cnt;
    int done_at;
    int sel_err;
    int busy_err;
    logic [7:0] w_at_done;
    n = 8 * (int'(d) + 2) + 1;
    done_cnt = 0;
    done_at = 0;
    sel_err = 0;
    busy_err = 0;
    w_at_done = 8'h00;
    div = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      if (c > 1) tick();
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
        w_at_done = word;
      end
      if (c < n && sel !== 4'((c - 1) / (int'(d) + 2))) sel_err++;
      if (busy !== (c <= n)) busy_err++;
      if (perturb && c == 10) begin
        start = 1'b1;
        div = 8'd0;
      end
      if (perturb && c == 11) start = 1'b0;
    end
    chk({tag, "_done_at"}, done_at, n);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_sel_err"}, sel_err, 0);
    chk({tag, "_busy_err"}, busy_err, 0);
    chk({tag, "_word_done"}, w_at_done, exp_w);
    chk({tag, "_word_hold"}, word, exp_w);
  endtask

  initial begin
    int d1, d2, nd;
    logic [7:0] w1, w2;
    logic b18, b19;

    rst_n = 1'b0;
    start = 1'b0;
    div = 8'd0;
    mux_data = 8'h00;
    #3;
    chk("rst_sel", sel, 0);
    chk("rst_word", word, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 1: async reset mid-frame on channel 4 with D=3
    mux_data = 8'hA6;
    div = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 22; c++) tick();
    chk("t1_sel_ch4", sel, 4);
    chk("t1_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_sel_async", sel, 0);
    chk("t1_word_async", word, 0);
    chk("t1_busy_async", busy, 0);
    chk("t1_done_async", done, 0);
    tick();
    chk("t1_done_held", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t1_busy_after", busy, 0);
    chk("t1_word_after", word, 0);

    // Test 2: D=0, word A6
    mux_data = 8'hA6;
    run_frame(8'd0, 8'hA6, 1'b0, "t2");

    // Test 3: D=5
    tick();
    run_frame(8'd5, 8'hA6, 1'b0, "t3");

    // Test 4: restart attempt and divider change mid-frame
    tick();
    mux_data = 8'hC3;
    run_frame(8'd5, 8'hC3, 1'b1, "t4");

    // Test 5: start held high, data changes between frames
    tick();
    mux_data = 8'hA6;
    div = 8'd0;
    d1 = 0;
    d2 = 0;
    nd = 0;
    w1 = 8'h00;
    w2 = 8'h00;
    b18 = 1'bx;
    b19 = 1'bx;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) tick();
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) begin
          d1 = c;
          w1 = word;
          mux_data = 8'h5B;
        end else if (nd == 2) begin
          d2 = c;
          w2 = word;
          start = 1'b0;
        end
      end
      if (c == 18) b18 = busy;
      if (c == 19) b19 = busy;
    end
    chk("t5_first_done", d1, 17);
    chk("t5_spacing", d2 - d1, 18);
    chk("t5_word1", w1, 8'hA6);
    chk("t5_word2", w2, 8'h5B);
    chk("t5_idle_gap", b18, 0);
    chk("t5_restart", b19, 1);
    chk("t5_pulses", nd, 2);

    // Test 6: D=255, no counter wrap
    tick();
    mux_data = 8'h3C;
    run_frame(8'd255, 8'h3C, 1'b0, "t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
